// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: operand address width, memory/register-file
// control enums and the hazard controller state encoding.
package pipeline_hazard_controller_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int WORD       = 32;

  typedef enum logic {
    NO_MEM_READ = 1'b0,
    MEM_READ    = 1'b1
  } mem_read_signal;

  typedef enum logic {
    NO_REG_WRITE = 1'b0,
    REG_WRITE    = 1'b1
  } reg_file_write_sig;

  typedef logic [0:0] hazard_state;
  localparam hazard_state RUN   = 1'b0;
  localparam hazard_state MULTI = 1'b1;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use hazard detection: a load in execute writes a register
// that the instruction in decode is about to read.
module load_use_detector
  import pipeline_hazard_controller_pkg::*;
(
  input  logic                  dec_valid_i,
  input  logic [ADDR_WIDTH-1:0] dec_reg_1_addr_i,
  input  logic                  dec_reg_1_used_i,
  input  logic [ADDR_WIDTH-1:0] dec_reg_2_addr_i,
  input  logic                  dec_reg_2_used_i,
  input  mem_read_signal        ex_mem_read_en_i,
  input  reg_file_write_sig     ex_reg_file_write_en_i,
  input  logic [ADDR_WIDTH-1:0] ex_reg_dest_addr_i,
  output logic                  lu_o
);

  logic src1_hit;
  logic src2_hit;
  logic ex_is_load;

  assign ex_is_load = (ex_mem_read_en_i == MEM_READ) && (ex_reg_file_write_en_i == REG_WRITE);
  assign src1_hit   = dec_reg_1_used_i && (dec_reg_1_addr_i == ex_reg_dest_addr_i);
  assign src2_hit   = dec_reg_2_used_i && (dec_reg_2_addr_i == ex_reg_dest_addr_i);
  assign lu_o       = dec_valid_i && ex_is_load && (src1_hit || src2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: stall/flush sequencing for PC, IF/ID and ID/EX.
// Optional performance counters are enabled with HAZARD_PERF_COUNTERS_EN.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MULTI_CYCLE_LAT = 4,
  parameter int CNT_WIDTH       = $clog2(MULTI_CYCLE_LAT),
  parameter int PERF_CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  dec_valid_i,
  input  logic [ADDR_WIDTH-1:0] dec_reg_1_addr_i,
  input  logic                  dec_reg_1_used_i,
  input  logic [ADDR_WIDTH-1:0] dec_reg_2_addr_i,
  input  logic                  dec_reg_2_used_i,
  input  logic                  dec_multi_cycle_i,
  input  mem_read_signal        ex_mem_read_en_i,
  input  reg_file_write_sig     ex_reg_file_write_en_i,
  input  logic [ADDR_WIDTH-1:0] ex_reg_dest_addr_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  mem_busy_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_stall_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_busy_o
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] stall_cycles_o,
  output logic [PERF_CNT_WIDTH-1:0] flush_count_o
`endif
);

  hazard_state          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lu;

  load_use_detector u_lu (
    .dec_valid_i            (dec_valid_i),
    .dec_reg_1_addr_i       (dec_reg_1_addr_i),
    .dec_reg_1_used_i       (dec_reg_1_used_i),
    .dec_reg_2_addr_i       (dec_reg_2_addr_i),
    .dec_reg_2_used_i       (dec_reg_2_used_i),
    .ex_mem_read_en_i       (ex_mem_read_en_i),
    .ex_reg_file_write_en_i (ex_reg_file_write_en_i),
    .ex_reg_dest_addr_i     (ex_reg_dest_addr_i),
    .lu_o                   (lu)
  );

  // Next-state and Mealy output decode; RUN conditions are in strict priority order
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall_o    = 1'b0;
    if_id_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_stall_o = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_busy_o     = 1'b0;
    if (reset_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (mem_busy_i) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
          end else if (lu) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (dec_valid_i && dec_multi_cycle_i) begin
            state_d = MULTI;
            cnt_d   = CNT_WIDTH'(MULTI_CYCLE_LAT - 1);
          end else begin
            state_d = RUN;
          end
        end
        MULTI: begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
          ex_busy_o     = 1'b1;
          if (!mem_busy_i) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) begin
              state_d = RUN;
            end else begin
              state_d = MULTI;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and multi-cycle counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [PERF_CNT_WIDTH-1:0] stall_cycles_q;
  logic [PERF_CNT_WIDTH-1:0] flush_count_q;

  // Free-running event counters; flushes during reset are not counted
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_q + PERF_CNT_WIDTH'(pc_stall_o);
      flush_count_q  <= flush_count_q + PERF_CNT_WIDTH'(if_id_flush_o);
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed vector table,
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  localparam int LAT = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                  reset_i;
  logic                  dec_valid_i;
  logic [ADDR_WIDTH-1:0] dec_reg_1_addr_i;
  logic                  dec_reg_1_used_i;
  logic [ADDR_WIDTH-1:0] dec_reg_2_addr_i;
  logic                  dec_reg_2_used_i;
  logic                  dec_multi_cycle_i;
  mem_read_signal        ex_mem_read_en_i;
  reg_file_write_sig     ex_reg_file_write_en_i;
  logic [ADDR_WIDTH-1:0] ex_reg_dest_addr_i;
  logic                  ex_branch_taken_i;
  logic                  mem_busy_i;
  logic pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, ex_busy_o;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;
`endif

  pipeline_hazard_controller #(.MULTI_CYCLE_LAT(LAT)) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .dec_valid_i            (dec_valid_i),
    .dec_reg_1_addr_i       (dec_reg_1_addr_i),
    .dec_reg_1_used_i       (dec_reg_1_used_i),
    .dec_reg_2_addr_i       (dec_reg_2_addr_i),
    .dec_reg_2_used_i       (dec_reg_2_used_i),
    .dec_multi_cycle_i      (dec_multi_cycle_i),
    .ex_mem_read_en_i       (ex_mem_read_en_i),
    .ex_reg_file_write_en_i (ex_reg_file_write_en_i),
    .ex_reg_dest_addr_i     (ex_reg_dest_addr_i),
    .ex_branch_taken_i      (ex_branch_taken_i),
    .mem_busy_i             (mem_busy_i),
    .pc_stall_o             (pc_stall_o),
    .if_id_stall_o          (if_id_stall_o),
    .if_id_flush_o          (if_id_flush_o),
    .id_ex_stall_o          (id_ex_stall_o),
    .id_ex_flush_o          (id_ex_flush_o),
    .ex_busy_o              (ex_busy_o)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .stall_cycles_o         (stall_cycles_o),
    .flush_count_o          (flush_count_o)
`endif
  );

  // exp bit order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_busy}
  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] a1;
    logic       u1;
    logic [4:0] a2;
    logic       u2;
    logic       multi;
    logic       mr;
    logic       we;
    logic [4:0] dest;
    logic       br;
    logic       mb;
    logic [5:0] exp;
  } vec_t;

  localparam logic [5:0] IDLE  = 6'b000000;
  localparam logic [5:0] RSTV  = 6'b001010;
  localparam logic [5:0] FLUSH = 6'b001010;
  localparam logic [5:0] HOLD  = 6'b110100;
  localparam logic [5:0] LUSE  = 6'b110010;
  localparam logic [5:0] BUSY  = 6'b110101;

  int vectors = 0;
  int miscompares = 0;

  function automatic vec_t mk(logic rst, logic valid, logic [4:0] a1, logic u1, logic [4:0] a2,
                              logic u2, logic multi, logic mr, logic we, logic [4:0] dest,
                              logic br, logic mb, logic [5:0] exp);
    vec_t v;
    v.rst = rst; v.valid = valid; v.a1 = a1; v.u1 = u1; v.a2 = a2; v.u2 = u2;
    v.multi = multi; v.mr = mr; v.we = we; v.dest = dest; v.br = br; v.mb = mb; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, compare mid-phase
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk_i);
    reset_i                = v.rst;
    dec_valid_i            = v.valid;
    dec_reg_1_addr_i       = v.a1;
    dec_reg_1_used_i       = v.u1;
    dec_reg_2_addr_i       = v.a2;
    dec_reg_2_used_i       = v.u2;
    dec_multi_cycle_i      = v.multi;
    ex_mem_read_en_i       = mem_read_signal'(v.mr);
    ex_reg_file_write_en_i = reg_file_write_sig'(v.we);
    ex_reg_dest_addr_i     = v.dest;
    ex_branch_taken_i      = v.br;
    mem_busy_i             = v.mb;
    #2;
    check(nm, {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, ex_busy_o}, v.exp);
  endtask

  vec_t tbl[17];
  vec_t idle_v;
  vec_t mop_v;

  // Reference model: a count of remaining multi-cycle hold cycles, rules applied in priority order
  int hold_left = 0;
  function automatic logic [5:0] model_out(input vec_t v);
    bit lu;
    lu = v.valid && v.mr && v.we && ((v.u1 && v.a1 == v.dest) || (v.u2 && v.a2 == v.dest));
    if (v.rst) return RSTV;
    if (hold_left > 0) return BUSY;
    if (v.br) return FLUSH;
    if (v.mb) return HOLD;
    if (lu) return LUSE;
    return IDLE;
  endfunction

  task automatic model_step(input vec_t v);
    bit lu;
    lu = v.valid && v.mr && v.we && ((v.u1 && v.a1 == v.dest) || (v.u2 && v.a2 == v.dest));
    if (v.rst) hold_left = 0;
    else if (hold_left > 0) begin
      if (!v.mb) hold_left = hold_left - 1;
    end else if (!v.br && !v.mb && !lu && v.valid && v.multi) hold_left = LAT - 1;
  endtask

  initial begin
    idle_v = mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, IDLE);
    mop_v  = mk(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, IDLE);

    //            rst   valid a1    u1    a2    u2    multi mr    we    dest  br    mb    exp
    tbl[0]  = mk(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, RSTV);
    tbl[1]  = mk(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, IDLE);
    tbl[2]  = mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, LUSE);
    tbl[3]  = mk(1'b0, 1'b1, 5'd3, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, IDLE);
    tbl[4]  = mk(1'b0, 1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, LUSE);
    tbl[5]  = mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, FLUSH);
    tbl[6]  = mk(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, HOLD);
    tbl[7]  = mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, HOLD);
    tbl[8]  = mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, IDLE);
    tbl[9]  = mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, IDLE);
    tbl[10] = mk(1'b0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, IDLE);
    tbl[11] = mk(1'b0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, LUSE);
    tbl[12] = mk(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, FLUSH);
    tbl[13] = mk(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, FLUSH);
    tbl[14] = idle_v;
    tbl[15] = mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, LUSE);
    tbl[16] = idle_v;

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("table[%0d]", i));

    // Multi-cycle op: 3 held cycles then RUN
    apply(mop_v, "multi_issue");
    for (int i = 0; i < LAT - 1; i++) apply(mk(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1,
                                               5'd3, 1'b1, 1'b0, BUSY), $sformatf("multi_hold[%0d]", i));
    apply(idle_v, "multi_done");

    // Multi-cycle op with two memory-wait cycles inside: 5 held cycles
    apply(mop_v, "multi_mb_issue");
    for (int i = 0; i < LAT + 1; i++) begin
      vec_t v;
      v = mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, BUSY);
      v.mb = (i == 1 || i == 2);
      apply(v, $sformatf("multi_mb_hold[%0d]", i));
    end
    apply(idle_v, "multi_mb_done");

    // Reset in the second MULTI cycle
    apply(mop_v, "multi_rst_issue");
    apply(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, BUSY), "multi_rst_hold");
    apply(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, RSTV), "multi_rst_during");
    apply(idle_v, "multi_rst_after");

`ifdef HAZARD_PERF_COUNTERS_EN
    apply(tbl[0], "perf_reset");
    apply(tbl[2], "perf_lu");
    apply(tbl[5], "perf_branch");
    apply(idle_v, "perf_idle");
    vectors++;
    if (stall_cycles_o !== 32'd1 || flush_count_o !== 32'd1) begin
      miscompares++;
      $display("FAIL perf_counters: got stall=%0d flush=%0d expected 1/1", stall_cycles_o, flush_count_o);
    end
`endif

    // Randomized traffic against the reference model
    apply(tbl[0], "rand_reset");
    hold_left = 0;
    for (int n = 0; n < 600; n++) begin
      vec_t v;
      v.rst   = ($urandom_range(0, 49) == 0);
      v.valid = ($urandom_range(0, 9) != 0);
      v.a1    = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom);
      v.a2    = 5'($urandom_range(0, 3));
      v.u2    = 1'($urandom);
      v.multi = ($urandom_range(0, 7) == 0);
      v.mr    = 1'($urandom);
      v.we    = ($urandom_range(0, 3) != 0);
      v.dest  = 5'($urandom_range(0, 3));
      v.br    = ($urandom_range(0, 9) == 0);
      v.mb    = ($urandom_range(0, 6) == 0);
      v.exp   = model_out(v);
      apply(v, $sformatf("random[%0d]", n));
      model_step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
